mem_bus_sched: RTL and testbench



---
 rtl/mem_bus_sched.sv | 143 ++++++++++++++
 tb/tb_mem_bus_sched.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_sched.sv
// mem_bus_sched: byte-serial RAM bus scheduler sharing the 8-bit bus between fetch and data requesters
// Define FAIR_RR_EN to let a waiting fetch win once after each data transaction.
module mem_bus_sched (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_req_in,
  input  logic [17:0] if_addr_in,
  input  logic        if_flush_in,
  output logic        if_done_out,
  output logic [31:0] if_data_out,
  input  logic        d_req_in,
  input  logic        d_we_in,
  input  logic [17:0] d_addr_in,
  input  logic [2:0]  d_len_in,
  input  logic [31:0] d_wdata_in,
  output logic        d_done_out,
  output logic [31:0] d_rdata_out,
  output logic        busy_out,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state;
  logic isData, pend, wrReg, grantData, lastCap;
  logic [17:0] base, memA;
  logic [2:0] len, issIdx, capIdx, nIss, dLen;
  logic [31:0] wdata, acc, nextAcc;
  logic [7:0] wByte;
`ifdef FAIR_RR_EN
  logic lastData;
  assign grantData = d_req_in && !(lastData && if_req_in);
`else
  assign grantData = d_req_in;
`endif
  assign dLen = (d_len_in == 3'd2 || d_len_in == 3'd4) ? d_len_in : 3'd1;
  assign nIss = issIdx + 3'd1;
  assign wByte = 8'(wdata >> {nIss, 3'b000});
  assign nextAcc = acc | (32'(mem_din) << {capIdx, 3'b000});
  assign lastCap = pend && capIdx == len - 3'd1;
  assign mem_a = {14'b0, memA};
  assign mem_wr = wrReg && rdy_in;
  assign busy_out = state != IDLE;
  // pend marks a byte whose address went out in the previous ready cycle
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      state <= IDLE;
      isData <= 1'b0;
      pend <= 1'b0;
      wrReg <= 1'b0;
      base <= '0;
      memA <= '0;
      len <= '0;
      issIdx <= '0;
      capIdx <= '0;
      wdata <= '0;
      acc <= '0;
      mem_dout <= '0;
      if_done_out <= 1'b0;
      if_data_out <= '0;
      d_done_out <= 1'b0;
      d_rdata_out <= '0;
`ifdef FAIR_RR_EN
      lastData <= 1'b0;
`endif
    end else if (!rdy_in) begin
      // the in-flight read byte is lost; rewind to the oldest uncaptured byte
      if (state == READ && pend) begin
        pend <= 1'b0;
        issIdx <= capIdx;
        memA <= base + 18'(capIdx);
      end
    end else case (state)
      IDLE: begin
`ifdef FAIR_RR_EN
        lastData <= grantData;
`endif
        if (d_req_in || if_req_in) begin
          state <= (grantData && d_we_in) ? WRITE : READ;
          isData <= grantData;
          base <= grantData ? d_addr_in : if_addr_in;
          memA <= grantData ? d_addr_in : if_addr_in;
          len <= grantData ? dLen : 3'd4;
          wdata <= d_wdata_in;
          mem_dout <= (grantData && d_we_in) ? d_wdata_in[7:0] : 8'd0;
          wrReg <= grantData && d_we_in;
          issIdx <= '0;
          capIdx <= '0;
          pend <= 1'b0;
          acc <= '0;
        end
      end
      READ: begin
        if (!isData && if_flush_in) begin
          state <= IDLE;
          memA <= '0;
          pend <= 1'b0;
          acc <= '0;
        end else begin
          if (pend) begin
            acc <= nextAcc;
            capIdx <= capIdx + 3'd1;
          end
          if (issIdx < len) begin
            pend <= 1'b1;
            issIdx <= nIss;
            memA <= nIss < len ? base + 18'(nIss) : 18'd0;
          end else pend <= 1'b0;
          if (lastCap) begin
            state <= DONE;
            if (isData) begin
              d_done_out <= 1'b1;
              d_rdata_out <= nextAcc;
            end else begin
              if_done_out <= 1'b1;
              if_data_out <= nextAcc;
            end
          end
        end
      end
      WRITE: begin
        if (nIss == len) begin
          state <= DONE;
          memA <= '0;
          mem_dout <= '0;
          wrReg <= 1'b0;
          d_done_out <= 1'b1;
        end else begin
          issIdx <= nIss;
          memA <= base + 18'(nIss);
          mem_dout <= wByte;
        end
      end
      DONE: begin
        state <= IDLE;
        if_done_out <= 1'b0;
        d_done_out <= 1'b0;
      end
      default: state <= IDLE;
    endcase
endmodule

// File: tb/tb_mem_bus_sched.sv
// tb_mem_bus_sched: directed bench for mem_bus_sched with a one-cycle-latency RAM model
module tb_mem_bus_sched;
  logic clk = 1'b0, rstN = 1'b0, rdy = 1'b1;
  logic ifReq = 1'b0, ifFlush = 1'b0, dReq = 1'b0, dWe = 1'b0;
  logic [17:0] ifAddr = '0, dAddr = '0;
  logic [2:0] dLen = 3'd1;
  logic [31:0] dWdata = '0;
  logic ifDone, dDone, busy, memWr;
  logic [31:0] ifData, dRdata, memA;
  logic [7:0] memDin, memDout;
  logic [7:0] ram [0:262143];
  int nCmp = 0, nFail = 0;

  mem_bus_sched dut (
    .clk_in(clk), .rst_in(rstN), .rdy_in(rdy),
    .if_req_in(ifReq), .if_addr_in(ifAddr), .if_flush_in(ifFlush),
    .if_done_out(ifDone), .if_data_out(ifData),
    .d_req_in(dReq), .d_we_in(dWe), .d_addr_in(dAddr), .d_len_in(dLen), .d_wdata_in(dWdata),
    .d_done_out(dDone), .d_rdata_out(dRdata), .busy_out(busy),
    .mem_din(memDin), .mem_dout(memDout), .mem_a(memA), .mem_wr(memWr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (memWr) ram[memA[17:0]] <= memDout;
    memDin <= ram[memA[17:0]];
  end

  task automatic test_reset();
    #12;
    nCmp++; if (memA !== 32'h0 || memWr !== 1'b0 || memDout !== 8'h0) begin nFail++; $display("FAIL reset_bus a=%h wr=%b dout=%h want 0", memA, memWr, memDout); end
    nCmp++; if (busy !== 1'b0 || ifDone !== 1'b0 || dDone !== 1'b0) begin nFail++; $display("FAIL reset_flags busy=%b ifd=%b dd=%b want 0", busy, ifDone, dDone); end
    @(posedge clk); #1; rstN = 1'b1;
  endtask

  task automatic test_fetch();
    ram[18'h100] = 8'h13; ram[18'h101] = 8'h05; ram[18'h102] = 8'h00; ram[18'h103] = 8'h00;
    @(posedge clk); #1; ifAddr = 18'h100; ifReq = 1'b1;
    @(negedge clk);
    nCmp++; if (memA !== 32'h0) begin nFail++; $display("FAIL fetch_idle_a got %h want 0", memA); end
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1; @(negedge clk);
      nCmp++; if (memA !== (k <= 4 ? 32'h100 + 32'(k - 1) : 32'h0)) begin nFail++; $display("FAIL fetch_a k=%0d got %h", k, memA); end
      nCmp++; if (ifDone !== (k == 6) || memWr !== 1'b0) begin nFail++; $display("FAIL fetch_done k=%0d got done=%b wr=%b", k, ifDone, memWr); end
      if (k == 6) begin
        nCmp++; if (ifData !== 32'h00000513) begin nFail++; $display("FAIL fetch_data got %h want 00000513", ifData); end
      end
    end
    @(posedge clk); #1; ifReq = 1'b0; @(negedge clk);
    nCmp++; if (busy !== 1'b0) begin nFail++; $display("FAIL fetch_busy got %b want 0", busy); end
  endtask

  task automatic test_store_wrap();
    @(posedge clk); #1; dReq = 1'b1; dWe = 1'b1; dAddr = 18'h3FFFF; dLen = 3'd2; dWdata = 32'hA1B2C3D4;
    @(negedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1; @(negedge clk);
      nCmp++; if (memA !== (k == 1 ? 32'h3FFFF : 32'h0)) begin nFail++; $display("FAIL store_a k=%0d got %h", k, memA); end
      nCmp++; if (memWr !== (k <= 2) || dDone !== (k == 3)) begin nFail++; $display("FAIL store_ctl k=%0d got wr=%b done=%b", k, memWr, dDone); end
      if (k <= 2) begin
        nCmp++; if (memDout !== (k == 1 ? 8'hD4 : 8'hC3)) begin nFail++; $display("FAIL store_dout k=%0d got %h", k, memDout); end
      end
    end
    @(posedge clk); #1; dReq = 1'b0; dWe = 1'b0;
    nCmp++; if (ram[18'h3FFFF] !== 8'hD4 || ram[18'h0] !== 8'hC3) begin nFail++; $display("FAIL store_ram got %h %h want d4 c3", ram[18'h3FFFF], ram[18'h0]); end
  endtask

  task automatic test_priority();
    logic seen;
    logic [31:0] expA5;
    ram[18'h200] = 8'h5A;
    ram[18'h300] = 8'h11; ram[18'h301] = 8'h22; ram[18'h302] = 8'h33; ram[18'h303] = 8'h44;
`ifdef FAIR_RR_EN
    expA5 = 32'h300;
`else
    expA5 = 32'h200;
`endif
    @(posedge clk); #1; dReq = 1'b1; dWe = 1'b0; dAddr = 18'h200; dLen = 3'd1; ifReq = 1'b1; ifAddr = 18'h300;
    @(negedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1; @(negedge clk);
      if (k == 1 || k == 4 || k == 5) begin
        nCmp++; if (memA !== (k == 1 ? 32'h200 : k == 4 ? 32'h0 : expA5)) begin nFail++; $display("FAIL prio_a k=%0d got %h", k, memA); end
      end
      if (k == 3) begin
        nCmp++; if (dDone !== 1'b1 || dRdata !== 32'h5A) begin nFail++; $display("FAIL prio_load got done=%b data=%h want 1 0000005a", dDone, dRdata); end
      end
    end
    @(posedge clk); #1; dReq = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk); seen = ifDone;
      if (!seen) begin @(posedge clk); #1; end
    end
    nCmp++; if (seen !== 1'b1 || ifData !== 32'h44332211) begin nFail++; $display("FAIL prio_fetch got done=%b data=%h want 1 44332211", seen, ifData); end
    @(posedge clk); #1; ifReq = 1'b0;
  endtask

  task automatic test_flush();
    logic sawIf = 1'b0;
    ram[18'h500] = 8'hEF; ram[18'h501] = 8'hBE;
    @(posedge clk); #1; ifReq = 1'b1; ifAddr = 18'h400;
    @(negedge clk);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin dReq = 1'b1; dWe = 1'b0; dAddr = 18'h500; dLen = 3'd2; end
      if (k == 3) ifFlush = 1'b1;
      if (k == 4) begin ifFlush = 1'b0; ifReq = 1'b0; end
      if (k == 9) dReq = 1'b0;
      @(negedge clk);
      sawIf = sawIf | ifDone;
      if (k == 3 || k == 5 || k == 6) begin
        nCmp++; if (memA !== (k == 3 ? 32'h402 : k == 5 ? 32'h500 : 32'h501)) begin nFail++; $display("FAIL flush_a k=%0d got %h", k, memA); end
      end
      if (k == 4) begin
        nCmp++; if (busy !== 1'b0 || memA !== 32'h0) begin nFail++; $display("FAIL flush_idle got busy=%b a=%h want 0 0", busy, memA); end
      end
      if (k == 8) begin
        nCmp++; if (dDone !== 1'b1 || dRdata !== 32'h0000BEEF) begin nFail++; $display("FAIL flush_load got done=%b data=%h want 1 0000beef", dDone, dRdata); end
      end
    end
    nCmp++; if (sawIf !== 1'b0) begin nFail++; $display("FAIL flush_nodone got %b want 0", sawIf); end
  endtask

  task automatic test_stall();
    logic [31:0] expA;
    ram[18'h1000] = 8'h01; ram[18'h1001] = 8'h23; ram[18'h1002] = 8'h45; ram[18'h1003] = 8'h67;
    @(posedge clk); #1; dReq = 1'b1; dWe = 1'b0; dAddr = 18'h1000; dLen = 3'd4;
    @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 3) rdy = 1'b0;
      if (k == 6) rdy = 1'b1;
      @(negedge clk);
      expA = k == 1 ? 32'h1000 : k == 2 ? 32'h1001 : k == 6 ? 32'h1001 : k == 7 ? 32'h1002 : k == 8 ? 32'h1003 : 32'h0;
      if (k < 3 || k > 5) begin
        nCmp++; if (memA !== expA) begin nFail++; $display("FAIL stall_a k=%0d got %h want %h", k, memA, expA); end
      end
      nCmp++; if (memWr !== 1'b0 || dDone !== (k == 10)) begin nFail++; $display("FAIL stall_ctl k=%0d got wr=%b done=%b", k, memWr, dDone); end
    end
    nCmp++; if (dRdata !== 32'h67452301) begin nFail++; $display("FAIL stall_data got %h want 67452301", dRdata); end
    @(posedge clk); #1; dReq = 1'b0;
  endtask

  task automatic test_len_io();
    ram[18'h30005] = 8'h9C;
    @(posedge clk); #1; dReq = 1'b1; dWe = 1'b0; dAddr = 18'h30005; dLen = 3'd3;
    @(negedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1; @(negedge clk);
      nCmp++; if (memA !== (k == 1 ? 32'h30005 : 32'h0)) begin nFail++; $display("FAIL io_a k=%0d got %h", k, memA); end
      nCmp++; if (dDone !== (k == 3)) begin nFail++; $display("FAIL io_done k=%0d got %b", k, dDone); end
    end
    nCmp++; if (dRdata !== 32'h0000009C) begin nFail++; $display("FAIL io_data got %h want 0000009c", dRdata); end
    @(posedge clk); #1; dReq = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    logic sawDone = 1'b0;
    @(posedge clk); #1; dReq = 1'b1; dWe = 1'b1; dAddr = 18'h600; dLen = 3'd4; dWdata = 32'h11223344;
    @(negedge clk);
    @(posedge clk); #1; @(negedge clk);
    nCmp++; if (memWr !== 1'b1 || memA !== 32'h600 || memDout !== 8'h44) begin nFail++; $display("FAIL rstw_first got wr=%b a=%h d=%h", memWr, memA, memDout); end
    @(posedge clk); #1; @(negedge clk);
    nCmp++; if (memA !== 32'h601 || memDout !== 8'h33) begin nFail++; $display("FAIL rstw_second got a=%h d=%h", memA, memDout); end
    #2; rstN = 1'b0; dReq = 1'b0; dWe = 1'b0; #1;
    nCmp++; if (memWr !== 1'b0 || memA !== 32'h0 || memDout !== 8'h0 || busy !== 1'b0) begin nFail++; $display("FAIL rstw_clear got wr=%b a=%h d=%h busy=%b", memWr, memA, memDout, busy); end
    @(posedge clk); #1; rstN = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); sawDone = sawDone | dDone | busy;
      @(posedge clk); #1;
    end
    nCmp++; if (sawDone !== 1'b0) begin nFail++; $display("FAIL rstw_quiet got %b want 0", sawDone); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_wrap();
    test_priority();
    test_flush();
    test_stall();
    test_len_io();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end
endmodule
